// File: rtl/sdram_cache_32.sv
// Direct-mapped, write-through, no-write-allocate one-word-line cache in front of the SDRAM controller.
// Optional hit/miss counters are enabled by defining SDRAM_CACHE_STATS_EN.
module sdram_cache_32 #(
  parameter int unsigned ADDRESS_WIDTH = 23,
  parameter int unsigned INDEX_BITS    = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [31:0]              cpu_data_in,
  input  logic [3:0]               cpu_nwr,
  input  logic                     cpu_req,
  output logic                     cpu_ack,
  output logic [31:0]              cpu_data_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_data_out,
  output logic [3:0]               mem_nwr,
  output logic                     mem_req,
  input  logic                     mem_ack,
`ifdef SDRAM_CACHE_STATS_EN
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count,
`endif
  input  logic [31:0]              mem_data_in
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDRESS_WIDTH - INDEX_BITS;

  typedef enum logic [2:0] {
    INIT, IDLE, LOOKUP, MEM, MEM_RELEASE, ACK_WAIT
  } state_t;

  state_t                   r_state;
  logic [INDEX_BITS-1:0]    r_init_idx;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_nwr;
  logic                     r_hit;
  logic                     r_cpu_ack;
  logic [31:0]              r_cpu_data_out;
  logic [3:0]               r_mem_nwr;
  logic                     r_mem_req;

  logic                     r_valid    [LINES];
  logic [TAG_BITS-1:0]      r_tag_ram  [LINES];
  logic [31:0]              r_data_ram [LINES];
  logic                     r_rd_valid;
  logic [TAG_BITS-1:0]      r_rd_tag;
  logic [31:0]              r_rd_data;

  logic [TAG_BITS-1:0]      w_addr_tag;
  logic [INDEX_BITS-1:0]    w_addr_idx;
  logic [INDEX_BITS-1:0]    w_cpu_idx;
  logic                     w_is_read;
  logic                     w_lookup_hit;
  logic                     w_accept;
  logic                     w_mem_done;
  logic                     w_fill;
  logic                     w_merge;
  logic [31:0]              w_merged;

  assign w_addr_tag   = r_addr[ADDRESS_WIDTH-1:INDEX_BITS];
  assign w_addr_idx   = r_addr[INDEX_BITS-1:0];
  assign w_cpu_idx    = cpu_address[INDEX_BITS-1:0];
  assign w_is_read    = (r_nwr == 4'hF);
  assign w_lookup_hit = r_rd_valid && (r_rd_tag == w_addr_tag);
  assign w_accept     = nreset && (r_state == IDLE) && cpu_req && !r_cpu_ack;
  assign w_mem_done   = (r_state == MEM) && mem_ack;
  assign w_fill       = nreset && w_mem_done && w_is_read;
  assign w_merge      = nreset && w_mem_done && !w_is_read && r_hit;

  assign cpu_ack      = r_cpu_ack;
  assign cpu_data_out = r_cpu_data_out;
  assign mem_nwr      = r_mem_nwr;
  assign mem_req      = r_mem_req;
  assign mem_address  = r_addr;
  assign mem_data_out = r_wdata;

  // Write hit keeps the bytes whose enable is high from the line read at accept time.
  always_comb begin
    w_merged = r_rd_data;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!r_nwr[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Tag/data/valid storage: synchronous read at accept, write on the controller ack edge.
  always_ff @(posedge clk) begin
    if (nreset && (r_state == INIT)) r_valid[r_init_idx] <= 1'b0;
    if (w_fill) begin
      r_valid[w_addr_idx]    <= 1'b1;
      r_tag_ram[w_addr_idx]  <= w_addr_tag;
      r_data_ram[w_addr_idx] <= mem_data_in;
    end else if (w_merge) begin
      r_data_ram[w_addr_idx] <= w_merged;
    end
    if (w_accept) begin
      r_rd_valid <= r_valid[w_cpu_idx];
      r_rd_tag   <= r_tag_ram[w_cpu_idx];
      r_rd_data  <= r_data_ram[w_cpu_idx];
    end
  end

`ifdef SDRAM_CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state        <= INIT;
      r_init_idx     <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_nwr          <= '1;
      r_hit          <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_cpu_data_out <= '0;
      r_mem_nwr      <= '1;
      r_mem_req      <= 1'b0;
`ifdef SDRAM_CACHE_STATS_EN
      r_hit_count    <= '0;
      r_miss_count   <= '0;
`endif
    end else begin
      case (r_state)
        INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (&r_init_idx) r_state <= IDLE;
        end
        IDLE: begin
          if (w_accept) begin
            r_addr  <= cpu_address;
            r_wdata <= cpu_data_in;
            r_nwr   <= cpu_nwr;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit <= w_lookup_hit;
          if (w_is_read && w_lookup_hit) begin
            r_cpu_data_out <= r_rd_data;
            r_cpu_ack      <= 1'b1;
            r_state        <= ACK_WAIT;
`ifdef SDRAM_CACHE_STATS_EN
            if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
`endif
          end else begin
            r_mem_req <= 1'b1;
            r_mem_nwr <= r_nwr;
            r_state   <= MEM;
`ifdef SDRAM_CACHE_STATS_EN
            if (w_is_read && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
`endif
          end
        end
        MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_cpu_ack <= 1'b1;
            if (w_is_read) r_cpu_data_out <= mem_data_in;
            r_state   <= MEM_RELEASE;
          end
        end
        MEM_RELEASE: begin
          if (!mem_ack && !cpu_req) begin
            r_cpu_ack <= 1'b0;
            r_state   <= IDLE;
          end
        end
        ACK_WAIT: begin
          if (!cpu_req) begin
            r_cpu_ack <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cache_32.sv
// Directed bench for sdram_cache_32 with a four-phase SDRAM controller model.
module tb_sdram_cache_32;

  logic        clk = 1'b0;
  logic        nreset;
  logic [22:0] cpu_address;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_nwr;
  logic        cpu_req;
  logic        cpu_ack;
  logic [31:0] cpu_data_out;
  logic [22:0] mem_address;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_nwr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_data_in;
`ifdef SDRAM_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  sdram_cache_32 #(.ADDRESS_WIDTH(23), .INDEX_BITS(8)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in), .cpu_nwr(cpu_nwr),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_data_out(cpu_data_out),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_nwr(mem_nwr),
    .mem_req(mem_req), .mem_ack(mem_ack),
`ifdef SDRAM_CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          req_count = 0;
  int          mem_delay = 2;
  int          mem_hold  = 0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  last_nwr  = '1;
  logic [22:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller model: acks mem_delay cycles after mem_req, keeps ack mem_hold cycles after req drops.
  initial begin
    mem_ack = 1'b0;
    mem_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !mem_ack) begin
        req_count++;
        last_nwr   = mem_nwr;
        last_addr  = mem_address;
        last_wdata = mem_data_out;
        repeat (mem_delay) @(posedge clk);
        #1;
        mem_data_in = mem_rdata;
        mem_ack = 1'b1;
        for (int k = 0; k < 1000 && mem_req; k++) begin
          @(posedge clk); #1;
        end
        repeat (mem_hold) @(posedge clk);
        if (mem_hold > 0) #1;
        mem_ack = 1'b0;
      end
    end
  end

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  // Called at #1 after an edge; lat = edges until cpu_ack, rel = edges from req drop until ack drops.
  task automatic cpu_txn(input logic [22:0] addr, input logic [31:0] wdata, input logic [3:0] nwr,
                         output logic [31:0] rdata, output int lat, output int rel);
    cpu_address = addr;
    cpu_data_in = wdata;
    cpu_nwr     = nwr;
    cpu_req     = 1'b1;
    lat = 0;
    rdata = '0;
    while (lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) break;
    end
    if (!cpu_ack) check("ack_timeout", 32'(cpu_ack), 32'd1);
    rdata   = cpu_data_out;
    cpu_req = 1'b0;
    rel = 0;
    while (rel < 1000) begin
      @(posedge clk); #1;
      rel++;
      if (!cpu_ack) break;
    end
    if (cpu_ack) check("release_timeout", 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, rel, r0;
    cpu_address = '0; cpu_data_in = '0; cpu_nwr = '1; cpu_req = 1'b0;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_nwr", 32'(mem_nwr), 32'hF);
    check("rst_data_out", cpu_data_out, 32'h0);
`ifdef SDRAM_CACHE_STATS_EN
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
`endif
    nreset = 1'b1;

    // First read issued at reset release: held off by 256 INIT cycles, then misses.
    mem_rdata = 32'hDEADBEEF;
    r0 = req_count;
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("miss0_lat", 32'(lat), 32'd261);
    check("miss0_data", rd, 32'hDEADBEEF);
    check("miss0_reqs", 32'(req_count - r0), 32'd1);
    check("miss0_nwr", 32'(last_nwr), 32'hF);
    check("miss0_addr", 32'(last_addr), 32'h000123);

    r0 = req_count;
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("hit1_lat", 32'(lat), 32'd2);
    check("hit1_data", rd, 32'hDEADBEEF);
    check("hit1_reqs", 32'(req_count - r0), 32'd0);

    r0 = req_count;
    cpu_txn(23'h000123, 32'h11223344, 4'b1100, rd, lat, rel);
    check("wr_hit_lat", 32'(lat), 32'd5);
    check("wr_hit_nwr", 32'(last_nwr), 32'hC);
    check("wr_hit_wdata", last_wdata, 32'h11223344);
    check("wr_hit_reqs", 32'(req_count - r0), 32'd1);
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("merge_lat", 32'(lat), 32'd2);
    check("merge_data", rd, 32'hDEAD3344);

    cpu_txn(23'h000223, 32'h55667788, 4'b0000, rd, lat, rel);
    check("wr_miss_lat", 32'(lat), 32'd5);
    check("wr_miss_addr", 32'(last_addr), 32'h000223);
    r0 = req_count;
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("after_wmiss_lat", 32'(lat), 32'd2);
    check("after_wmiss_data", rd, 32'hDEAD3344);
    check("after_wmiss_reqs", 32'(req_count - r0), 32'd0);

    mem_rdata = 32'hCAFEF00D;
    cpu_txn(23'h000223, '0, 4'hF, rd, lat, rel);
    check("evict_lat", 32'(lat), 32'd5);
    check("evict_data", rd, 32'hCAFEF00D);
    mem_rdata = 32'h12345678;
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("evicted_lat", 32'(lat), 32'd5);
    check("evicted_data", rd, 32'h12345678);

    // Controller keeps ack high 5 cycles after req drops.
    mem_hold = 5;
    mem_rdata = 32'hA5A5A5A5;
    r0 = req_count;
    cpu_txn(23'h000456, '0, 4'hF, rd, lat, rel);
    check("hold_lat", 32'(lat), 32'd5);
    check("hold_data", rd, 32'hA5A5A5A5);
    check("hold_release", 32'(rel), 32'd6);
    check("hold_reqs", 32'(req_count - r0), 32'd1);
    check("hold_mem_req", 32'(mem_req), 32'd0);
    mem_hold = 0;

`ifdef SDRAM_CACHE_STATS_EN
    check("stat_hits", 32'(hit_count), 32'd3);
    check("stat_misses", 32'(miss_count), 32'd4);
`endif

    // Reset while waiting in MEM.
    mem_delay = 20;
    cpu_address = 23'h000789; cpu_nwr = 4'hF; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("inmem_mem_req", 32'(mem_req), 32'd1);
    nreset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_cpu_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    mem_delay = 2;
`ifdef SDRAM_CACHE_STATS_EN
    check("rst_mid_hits", 32'(hit_count), 32'd0);
    check("rst_mid_misses", 32'(miss_count), 32'd0);
`endif

    mem_rdata = 32'h0BADF00D;
    r0 = req_count;
    cpu_txn(23'h000123, '0, 4'hF, rd, lat, rel);
    check("post_rst_lat", 32'(lat), 32'd261);
    check("post_rst_data", rd, 32'h0BADF00D);
    check("post_rst_reqs", 32'(req_count - r0), 32'd1);
    mem_rdata = 32'h600DCAFE;
    cpu_txn(23'h000456, '0, 4'hF, rd, lat, rel);
    check("post_rst_456_lat", 32'(lat), 32'd5);
    check("post_rst_456_data", rd, 32'h600DCAFE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_cache_32.md
# sdram_cache_32

Direct-mapped, write-through, no-write-allocate word cache between the 32-bit CPU bus and the 16-to-32 SDRAM controller. Read hits return from on-chip tag/data RAM without touching SDRAM. Misses and all writes are forwarded over the controller's four-phase req/ack handshake. Line size is one 32-bit word.

## Interface
- ADDRESS_WIDTH, 23, CPU word-address width; equals controller address width (bank+row+column-1).
- INDEX_BITS, 8, cache index width; 2^INDEX_BITS lines; tag width = ADDRESS_WIDTH-INDEX_BITS.
- clk  in  1  system clock.
- nreset  in  1  synchronous, active-low reset.
- cpu_address  in  ADDRESS_WIDTH  word address; stable while cpu_req high.
- cpu_data_in  in  32  write data.
- cpu_nwr  in  4  active-low byte write enables; 4'b1111 = read.
- cpu_req  in  1  request; held until cpu_ack seen, then dropped.
- cpu_ack  out  1  completion; held until cpu_req low.
- cpu_data_out  out  32  read data; valid while cpu_ack high.
- mem_address  out  ADDRESS_WIDTH  to controller cpu_address.
- mem_data_out  out  32  to controller cpu_data_in.
- mem_nwr  out  4  to controller cpu_nwr.
- mem_req  out  1  to controller cpu_req.
- mem_ack  in  1  from controller cpu_ack.
- mem_data_in  in  32  from controller cpu_data_out.

## Operation
- States: INIT, IDLE, LOOKUP, MEM, MEM_RELEASE, ACK_WAIT.
- Reset: cpu_ack=0, mem_req=0, cpu_data_out=0, mem_nwr=4'hF, state INIT, index counter 0. Reset mid-transaction abandons it; mem_req drops at the reset edge.
- INIT: clears one valid bit per cycle over indices 0..2^INDEX_BITS-1, then goes to IDLE. cpu_req is ignored during INIT.
- IDLE: on cpu_req & !cpu_ack, latches address, data and nwr; issues the tag/data RAM read; goes to LOOKUP.
- LOOKUP, hit = valid & tag match.
  - Read hit: cpu_data_out<=line, cpu_ack<=1, go to ACK_WAIT.
  - Read miss: mem_req<=1, mem_nwr=4'hF, go to MEM.
  - Write, hit or miss: mem_req<=1, mem_nwr<=latched nwr, go to MEM.
- MEM: waits for mem_ack. On mem_ack it sets mem_req<=0, cpu_ack<=1, goes to MEM_RELEASE, and then:
  - Read: cpu_data_out<=mem_data_in; line filled, tag written, valid set.
  - Write hit: only bytes with nwr[i]=0 are updated in the line.
  - Write miss: cache unchanged.
- MEM_RELEASE: waits until mem_ack=0 and cpu_req=0, then cpu_ack<=0 and goes to IDLE. This guarantees the controller has returned to its idle before the next mem_req.
- ACK_WAIT: when cpu_req=0, cpu_ack<=0, go to IDLE.
- mem_address and mem_data_out come from the latched values and are stable while mem_req is high.
- Fill and byte-merge arithmetic: per-byte mux, no width extension. The tag is cpu_address[ADDRESS_WIDTH-1:INDEX_BITS] and the index is cpu_address[INDEX_BITS-1:0].

## Timing
- Tag/data RAM: synchronous read, 1 cycle; write on the clock edge.
- Read hit: cpu_req sampled at edge E0; cpu_ack high after E1 (2-cycle latency).
- Miss or write: mem_req high after E1. cpu_ack rises on the same edge mem_ack is sampled high.
- Minimum idle between transactions: 1 cycle in IDLE after cpu_ack falls.
- A new cpu_req while cpu_ack is still high is not accepted.
- Back-to-back access to the same index, fill then read: the second access hits, because the RAM write completes before the next LOOKUP.
- INIT takes exactly 2^INDEX_BITS cycles after reset release.

## Configuration
- SDRAM_CACHE_STATS_EN defined: adds two outputs, hit_count and miss_count, each 16 bits, saturating at 16'hFFFF and cleared by reset.
  - hit_count increments on read hits in LOOKUP.
  - miss_count increments on read misses in LOOKUP.
  - Writes are not counted.
- SDRAM_CACHE_STATS_EN not defined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then read 0x000123 while the memory model returns 0xDEADBEEF: cpu_ack is not asserted before INIT ends (256 cycles); the first read misses, with exactly one mem_req and data 0xDEADBEEF.
- Repeat the read of 0x000123: hit, cpu_ack after 2 cycles, no mem_req, data 0xDEADBEEF.
- Write 0x000123 with cpu_nwr=4'b1100 and data 0x11223344: mem_req with mem_nwr=4'b1100; a following read hits and returns 0xDEAD3344.
- Write-miss to 0x000223 (same index, different tag), then read 0x000123: still a hit with 0xDEAD3344. Reading 0x000223 then misses and evicts the line.
- Memory model holds mem_ack high for 5 cycles after mem_req drops: cpu_ack stays high until mem_ack falls; no new mem_req is issued before that.
- Assert nreset while in MEM: mem_req=0 and cpu_ack=0 after the edge, state returns to INIT, and all lines are invalid afterwards. With SDRAM_CACHE_STATS_EN defined, both counters read 0.
